// File: rtl/tpu_ctrl_pkg.sv
// Shared types and defaults for the TPU tile sequencer and its result-window timer.
package tpu_ctrl_pkg;
  localparam int DEF_ADDRESSSIZE   = 10;
  localparam int DEF_MATRIX_SIZE   = 8;
  localparam int DEF_RELOAD_CYCLES = 1;
  localparam int DEF_PIPE_LATENCY  = 17;
  localparam int DEF_TILE_CNT_BW   = 8;
  localparam int CNT_W             = 16;

  typedef logic [DEF_ADDRESSSIZE-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_W, S_RELOAD, S_STREAM, S_DRAIN, S_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    T_IDLE, T_WAIT, T_WIN
  } win_phase_e;
endpackage

// File: rtl/tpu_tile_sequencer_result_window_timer.sv
// Result-SRAM write window: waits PIPE_LATENCY cycles after launch, then
// opens a MATRIX_SIZE-cycle window reporting row index j and a last-row pulse.
module result_window_timer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE  = DEF_ADDRESSSIZE,
  parameter int MATRIX_SIZE  = DEF_MATRIX_SIZE,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_launch,
  input  logic [ADDRESSSIZE-1:0] i_base,
  output logic                   o_active,
  output logic [CNT_W-1:0]       o_j,
  output logic [ADDRESSSIZE-1:0] o_base,
  output logic                   o_done
);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(PIPE_LATENCY > 1 ? PIPE_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] J_LAST    = CNT_W'(MATRIX_SIZE - 1);

  win_phase_e             r_phase;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_j;
  logic [ADDRESSSIZE-1:0] r_pend;
  logic [ADDRESSSIZE-1:0] r_base;

  // Base is only published on window entry so the visible address holds
  // its previous value while the next tile is still in its latency wait.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_phase <= T_IDLE;
      r_cnt   <= '0;
      r_j     <= '0;
      r_pend  <= '0;
      r_base  <= '0;
    end else begin
      case (r_phase)
        T_WAIT: begin
          if (r_cnt == '0) begin
            r_phase <= T_WIN;
            r_base  <= r_pend;
            r_j     <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        T_WIN: begin
          if (r_j == J_LAST) r_phase <= T_IDLE;
          else               r_j     <= r_j + CNT_W'(1);
        end
        default: begin
          if (i_launch) begin
            r_pend <= i_base;
            if (PIPE_LATENCY == 1) begin
              r_phase <= T_WIN;
              r_base  <= i_base;
              r_j     <= '0;
            end else begin
              r_phase <= T_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
      endcase
    end
  end

  assign o_active = (r_phase == T_WIN);
  assign o_j      = r_j;
  assign o_base   = r_base;
  assign o_done   = o_active && (r_j == J_LAST);
endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: per tile pops a weight set, pulses reload, streams UB rows
// and waits for the matching result-SRAM write window before the next tile.
module tpu_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE   = DEF_ADDRESSSIZE,
  parameter int MATRIX_SIZE   = DEF_MATRIX_SIZE,
  parameter int RELOAD_CYCLES = DEF_RELOAD_CYCLES,
  parameter int PIPE_LATENCY  = DEF_PIPE_LATENCY,
  parameter int TILE_CNT_BW   = DEF_TILE_CNT_BW
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [TILE_CNT_BW-1:0] num_tiles,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic [TILE_CNT_BW-1:0] tile_idx,
  output logic                   end_
);
  localparam logic [ADDRESSSIZE-1:0] ADDR_STEP = ADDRESSSIZE'(MATRIX_SIZE);

  seq_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [TILE_CNT_BW-1:0] r_num;
  logic [TILE_CNT_BW-1:0] r_tile;
  logic [ADDRESSSIZE-1:0] r_ub_ptr;
  logic [ADDRESSSIZE-1:0] r_res_ptr;
  logic [ADDRESSSIZE-1:0] r_ub_addr;

  logic                   w_launch;
  logic                   w_win_active;
  logic                   w_win_done;
  logic [CNT_W-1:0]       w_j;
  logic [ADDRESSSIZE-1:0] w_win_base;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_num     <= '0;
      r_tile    <= '0;
      r_ub_ptr  <= '0;
      r_res_ptr <= '0;
      r_ub_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num     <= num_tiles;
            r_ub_ptr  <= ub_base;
            r_res_ptr <= res_base;
            r_tile    <= '0;
            r_state   <= (num_tiles == '0) ? S_DONE : S_FETCH_W;
          end
        end
        S_FETCH_W: begin
          if (!fifo_empty) begin
            r_cnt   <= '0;
            r_state <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          if (r_cnt == CNT_W'(RELOAD_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_ub_addr <= r_ub_ptr;
            r_state   <= S_STREAM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STREAM: begin
          if (r_cnt == CNT_W'(MATRIX_SIZE - 1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_ub_addr <= r_ub_addr + ADDRESSSIZE'(1);
          end
        end
        S_DRAIN: begin
          // Next pop waits for the last result row so tiles never overlap.
          if (w_win_done) begin
            r_ub_ptr  <= r_ub_ptr + ADDR_STEP;
            r_res_ptr <= r_res_ptr + ADDR_STEP;
            if (r_tile == r_num - TILE_CNT_BW'(1)) begin
              r_state <= S_DONE;
            end else begin
              r_tile  <= r_tile + TILE_CNT_BW'(1);
              r_state <= S_FETCH_W;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_launch = (r_state == S_STREAM) && (r_cnt == '0);

  result_window_timer #(
    .ADDRESSSIZE (ADDRESSSIZE),
    .MATRIX_SIZE (MATRIX_SIZE),
    .PIPE_LATENCY(PIPE_LATENCY)
  ) u_win (
    .clk     (clk),
    .rstn    (rstn),
    .i_launch(w_launch),
    .i_base  (r_res_ptr),
    .o_active(w_win_active),
    .o_j     (w_j),
    .o_base  (w_win_base),
    .o_done  (w_win_done)
  );

  assign fifo_read_enable = (r_state == S_FETCH_W) && !fifo_empty;
  assign we_rl            = (r_state == S_RELOAD);
  assign ub_address       = r_ub_addr;
  assign res_write_enable = w_win_active;
  assign res_address      = w_win_base + ADDRESSSIZE'(w_j);
  assign busy             = (r_state != S_IDLE);
  assign tile_idx         = r_tile;
  assign end_             = (r_state == S_DONE);
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: a per-scenario schedule model filled from the
// tile timing rules, checked every cycle, plus hand-computed pins and counts.
module tb_tpu_tile_sequencer;
  localparam int AW = 10, MS = 8, PL = 17, RC = 1, TB = 8, MAXC = 128;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [TB-1:0] num_tiles = '0;
  logic [AW-1:0] ub_base = '0, res_base = '0;
  logic          fifo_empty = 1'b0;
  logic          fifo_read_enable, we_rl, res_write_enable, busy, end_;
  logic [AW-1:0] ub_address, res_address;
  logic [TB-1:0] tile_idx;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .ADDRESSSIZE(AW), .MATRIX_SIZE(MS), .RELOAD_CYCLES(RC),
    .PIPE_LATENCY(PL), .TILE_CNT_BW(TB)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles),
    .ub_base(ub_base), .res_base(res_base), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable), .we_rl(we_rl), .ub_address(ub_address),
    .res_write_enable(res_write_enable), .res_address(res_address),
    .busy(busy), .tile_idx(tile_idx), .end_(end_)
  );

  int errors = 0, checks = 0;
  int e_pop[MAXC], e_we[MAXC], e_ub[MAXC], e_rwe[MAXC];
  int e_ra[MAXC], e_busy[MAXC], e_end[MAXC], e_tidx[MAXC];
  int cur_c = 0, scen_len = 0;
  bit chk_en = 1'b0;
  int pin_n = 0;
  int pin_k[10], pin_c[10], pin_v[10];
  int lit_pops = 0, lit_ends = 0;
  int n_pop = 0, n_end = 0;

  task automatic chk(input string nm, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  function automatic int pick(input int k, input int c);
    case (k)
      0: return e_pop[c];
      1: return e_we[c];
      2: return e_ub[c];
      3: return e_rwe[c];
      4: return e_ra[c];
      5: return e_busy[c];
      6: return e_end[c];
      default: return e_tidx[c];
    endcase
  endfunction

  // Expected per-cycle outputs from the tile timeline: pop at first non-empty
  // fetch cycle, RC reload cycles, MS rows, window PL cycles after first row.
  function automatic void build(input int st, input int nt, input int ub, input int rb,
                                input int fe_lo, input int fe_hi, input int rst_c);
    int ub_s[MAXC], ra_s[MAXC], ti_s[MAXC];
    int t, f, s, hu, hr, ht;
    for (int c = 0; c < MAXC; c++) begin
      e_pop[c] = 0; e_we[c] = 0; e_rwe[c] = 0; e_busy[c] = 0; e_end[c] = 0;
      ub_s[c] = -1; ra_s[c] = -1; ti_s[c] = -1;
    end
    t = st + 1;
    ti_s[t] = 0;
    for (int i = 0; i < nt; i++) begin
      f = t;
      while (f >= fe_lo && f <= fe_hi) f++;
      e_pop[f] = 1;
      for (int r = 1; r <= RC; r++) e_we[f + r] = 1;
      s = f + RC + 1;
      for (int k = 0; k < MS; k++) ub_s[s + k] = (ub + i * MS + k) & AMASK;
      for (int j = 0; j < MS; j++) begin
        e_rwe[s + PL + j] = 1;
        ra_s[s + PL + j]  = (rb + i * MS + j) & AMASK;
      end
      for (int c = t; c < s + PL + MS; c++) ti_s[c] = i;
      t = s + PL + MS;
    end
    e_end[t] = 1;
    for (int c = st + 1; c <= t; c++) e_busy[c] = 1;
    hu = 0; hr = 0; ht = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (ub_s[c] >= 0) hu = ub_s[c];
      if (ra_s[c] >= 0) hr = ra_s[c];
      if (ti_s[c] >= 0) ht = ti_s[c];
      e_ub[c] = hu; e_ra[c] = hr; e_tidx[c] = ht;
    end
    if (rst_c >= 0)
      for (int c = rst_c + 1; c < MAXC; c++) begin
        e_pop[c] = 0; e_we[c] = 0; e_ub[c] = 0; e_rwe[c] = 0;
        e_ra[c] = 0; e_busy[c] = 0; e_end[c] = 0; e_tidx[c] = 0;
      end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (cur_c == 0) begin
        n_pop = 0; n_end = 0;
        for (int p = 0; p < pin_n; p++)
          chk($sformatf("model_pin%0d_k%0d", p, pin_k[p]), pin_c[p], pick(pin_k[p], pin_c[p]), pin_v[p]);
      end
      chk("fifo_read_enable", cur_c, int'(fifo_read_enable), e_pop[cur_c]);
      chk("we_rl",            cur_c, int'(we_rl),            e_we[cur_c]);
      chk("ub_address",       cur_c, int'(ub_address),       e_ub[cur_c]);
      chk("res_write_enable", cur_c, int'(res_write_enable), e_rwe[cur_c]);
      chk("res_address",      cur_c, int'(res_address),      e_ra[cur_c]);
      chk("busy",             cur_c, int'(busy),             e_busy[cur_c]);
      chk("end_",             cur_c, int'(end_),             e_end[cur_c]);
      chk("tile_idx",         cur_c, int'(tile_idx),         e_tidx[cur_c]);
      n_pop += int'(fifo_read_enable);
      n_end += int'(end_);
      if (cur_c == scen_len - 1) begin
        chk("pop_count", cur_c, n_pop, lit_pops);
        chk("end_count", cur_c, n_end, lit_ends);
      end
    end
  end

  task automatic pin(input int k, input int c, input int v);
    pin_k[pin_n] = k; pin_c[pin_n] = c; pin_v[pin_n] = v; pin_n++;
  endtask

  task automatic run(input bit do_rst, input int st, input int nt, input int ub, input int rb,
                     input int fe_lo, input int fe_hi, input int rst_c, input int xs,
                     input int len, input int pops, input int ends);
    @(posedge clk); #1;
    chk_en = 1'b0; start = 1'b0; fifo_empty = 1'b0;
    if (do_rst) begin
      rstn = 1'b0;
      @(posedge clk); #1;
    end
    num_tiles = TB'(nt); ub_base = AW'(ub); res_base = AW'(rb);
    build(st, nt, ub, rb, fe_lo, fe_hi, rst_c);
    scen_len = len; lit_pops = pops; lit_ends = ends;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      cur_c      = c;
      start      = (c == st) || (c == xs);
      fifo_empty = (c >= fe_lo) && (c <= fe_hi);
      rstn       = (c != rst_c);
      chk_en     = 1'b1;
    end
    @(posedge clk); #1;
    chk_en = 1'b0; start = 1'b0;
    pin_n = 0;
  endtask

  initial begin
    // single tile, default timing
    pin(0, 1, 1); pin(1, 2, 1); pin(2, 3, 'h010); pin(2, 10, 'h017); pin(3, 19, 0);
    pin(3, 20, 1); pin(4, 27, 'h027); pin(6, 28, 1); pin(5, 29, 0); pin(5, 1, 1);
    run(1, 0, 1, 'h010, 'h020, -1, -2, -1, -1, 34, 1, 1);
    // three tiles back to back
    pin(7, 28, 1); pin(0, 28, 1); pin(7, 55, 2); pin(4, 81, 'h037); pin(2, 57, 'h020); pin(6, 82, 1);
    run(1, 0, 3, 'h010, 'h020, -1, -2, -1, -1, 86, 3, 1);
    // FIFO empty for 5 fetch cycles
    pin(0, 1, 0); pin(0, 6, 1); pin(1, 7, 1); pin(3, 25, 1); pin(6, 33, 1);
    run(1, 0, 1, 'h010, 'h020, 1, 5, -1, -1, 38, 1, 1);
    // UB and result address wrap
    pin(2, 6, 'h3FF); pin(2, 7, 'h000); pin(2, 10, 'h003); pin(4, 26, 'h000); pin(4, 27, 'h001);
    run(1, 0, 1, 'h3FC, 'h3FA, -1, -2, -1, -1, 34, 1, 1);
    // num_tiles == 0
    pin(6, 2, 1); pin(5, 2, 1); pin(5, 3, 0); pin(0, 2, 0);
    run(1, 1, 0, 'h040, 'h050, -1, -2, -1, -1, 8, 0, 1);
    // second start mid-run is ignored
    pin(6, 28, 1); pin(2, 10, 'h017);
    run(1, 0, 1, 'h010, 'h020, -1, -2, -1, 10, 34, 1, 1);
    // reset during STREAM aborts cleanly
    pin(5, 5, 1); pin(2, 5, 'h012); pin(5, 6, 0); pin(2, 6, 0); pin(3, 20, 0);
    run(1, 0, 1, 'h010, 'h020, -1, -2, 5, -1, 34, 1, 0);
    // fresh run straight after the aborted one
    pin(2, 3, 'h100); pin(4, 20, 'h200); pin(6, 28, 1);
    run(0, 0, 1, 'h100, 'h200, -1, -2, -1, -1, 32, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
